// File: rtl/mem_pkg.sv
// Shared types for the memory request controller: FIFO entry layout and FSM states.
package mem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DST_W  = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DST_W-1:0]  dst;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} mem_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; push is ignored at full, pop at empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// Queues load/store requests and issues them one at a time on the 8-bit bus,
// returning each completion (or timeout abort) to the memory access unit.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DST_W-1:0]  req_dst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mau_en,
    output logic              mau_mem_res,
    output logic [DATA_W-1:0] mau_data,
    output logic [DST_W-1:0]  mau_dst,
    output logic              busy,
    output logic              err
);
    mem_req_t    req_in, head;
    logic        fifo_full, fifo_empty, pop;
    mem_state_e  state, state_nxt;
    logic [7:0]  cnt;
    logic        ack_ok, abort;
    logic        we_q, ok_q;
    logic [DST_W-1:0]  dst_q;
    logic [DATA_W-1:0] rdata_q;

    assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata, dst: req_dst};
    assign req_ready = !fifo_full;

    sync_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .push  (req_valid),
        .pop   (pop),
        .din   (req_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Ack wins over the timeout threshold when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ack_ok    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop       = 1'b1;
                state_nxt = BUS;
            end
            BUS: if (mem_ack) begin
                ack_ok    = 1'b1;
                state_nxt = RESP;
            end else if (cnt == 8'(TIMEOUT-1)) begin
                abort     = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            we_q      <= 1'b0;
            ok_q      <= 1'b0;
            dst_q     <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
        end else if (pop) begin
            mem_req   <= 1'b1;
            mem_we    <= head.we;
            mem_addr  <= head.addr;
            mem_wdata <= head.wdata;
            we_q      <= head.we;
            dst_q     <= head.dst;
            ok_q      <= 1'b0;
            cnt       <= '0;
        end else if (state == BUS) begin
            if (ack_ok || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (ack_ok) begin
                ok_q    <= 1'b1;
                rdata_q <= mem_rdata;
            end
            if (abort) err <= 1'b1;
        end
    end

    // Completion bundle is live only in RESP so mau sees zeros otherwise.
    assign mau_en      = (state == RESP);
    assign mau_mem_res = mau_en && !we_q && ok_q;
    assign mau_data    = mau_mem_res ? rdata_q : '0;
    assign mau_dst     = mau_en ? dst_q : '0;
    assign busy        = !fifo_empty || (state != IDLE);
endmodule
